// File: rtl/pll_lock_sequencer_if.sv
// pll_lock_sequencer_if: PLL-side and downstream control signals of the lock sequencer.
interface pll_lock_sequencer_if;
    logic       pll_lock;
    logic       pll_reset;
    logic       rst_out_n;
    logic       locked;
    logic       fault;
    logic [3:0] retry_cnt;

    modport master (
        input  pll_lock,
        output pll_reset, rst_out_n, locked, fault, retry_cnt
    );

    modport slave (
        output pll_lock,
        input  pll_reset, rst_out_n, locked, fault, retry_cnt
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: rPLL reset/lock controller with lock qualification, bounded retry and sticky fault.
module pll_lock_sequencer #(
    parameter int RESET_CYCLES = 16,
    parameter int LOCK_TIMEOUT = 27000,
    parameter int LOCK_STABLE  = 256,
    parameter int MAX_RETRIES  = 3
) (
    input logic                  sys_clk,
    input logic                  sys_rst_n,
    pll_lock_sequencer_if.master bus
);
    localparam int M01  = RESET_CYCLES > LOCK_TIMEOUT ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int MAXP = M01 > LOCK_STABLE ? M01 : LOCK_STABLE;
    localparam int CW   = $clog2(MAXP > 2 ? MAXP : 2);

    typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, STABLE, RUN, FAULT} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    retry, retry_n;
    logic [1:0]    sync;
    logic          lock_s;

    assign lock_s        = sync[1];
    assign bus.retry_cnt = retry;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync          <= '0;
            state         <= RESET_PLL;
            cnt           <= '0;
            retry         <= '0;
            bus.pll_reset <= 1'b1;
            bus.rst_out_n <= 1'b0;
            bus.locked    <= 1'b0;
            bus.fault     <= 1'b0;
        end else begin
            sync          <= {sync[0], bus.pll_lock};
            state         <= state_n;
            cnt           <= cnt_n;
            retry         <= retry_n;
            bus.pll_reset <= state_n == RESET_PLL || state_n == FAULT;
            bus.rst_out_n <= state_n == RUN;
            bus.locked    <= state_n == RUN;
            bus.fault     <= state_n == FAULT;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        retry_n = retry;
        case (state)
            RESET_PLL: begin
                if (cnt == CW'(RESET_CYCLES - 1)) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end
            end
            WAIT_LOCK: begin
                // Lock seen on the timeout cycle takes priority over the retry
                if (lock_s) begin
                    state_n = STABLE;
                    cnt_n   = '0;
                end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                    retry_n = retry + 1'b1;
                    state_n = retry_n == 4'(MAX_RETRIES) ? FAULT : RESET_PLL;
                    cnt_n   = '0;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt == CW'(LOCK_STABLE - 1)) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end
            end
            RUN: begin
                cnt_n = '0;
                if (!lock_s) begin
                    state_n = RESET_PLL;
                    retry_n = '0;
                end
            end
            FAULT: cnt_n = '0;
            default: begin
                state_n = RESET_PLL;
                cnt_n   = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: scenario tasks with an expected-latency scoreboard for the lock sequencer.
module tb_pll_lock_sequencer;
    localparam int RC = 4, LT = 50, LS = 8, MR = 3;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   exp_q[$];

    pll_lock_sequencer_if bus();

    pll_lock_sequencer #(
        .RESET_CYCLES(RC), .LOCK_TIMEOUT(LT), .LOCK_STABLE(LS), .MAX_RETRIES(MR)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus)
    );

    initial forever #5 sys_clk = ~sys_clk;

    task automatic tick(input int k = 1);
        repeat (k) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0: return bus.pll_reset;
            1: return bus.locked;
            default: return bus.fault;
        endcase
    endfunction

    // Edge count until the selected output reaches val; -1 if the budget runs out
    task automatic wait_sig(input int sel, input logic val, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (sig(sel) === val) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic check_lat(input string name, input int n);
        int e;
        e = exp_q.pop_front();
        checks++;
        if (n !== e) begin
            failures++;
            $display("FAIL %s: edges=%0d required=%0d", name, n, e);
        end
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        bus.pll_lock = 1'b0;
        tick(3);
        sys_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        sys_rst_n = 1'b0;
        bus.pll_lock = 1'b0;
        tick(3);
        checks++;
        if ({bus.pll_reset, bus.rst_out_n, bus.locked, bus.fault, bus.retry_cnt} !== 8'b1000_0000) begin
            failures++;
            $display("FAIL reset_values: got=%b required=%b",
                     {bus.pll_reset, bus.rst_out_n, bus.locked, bus.fault, bus.retry_cnt}, 8'b1000_0000);
        end
        sys_rst_n = 1'b1;
        exp_q.push_back(RC);
        wait_sig(0, 1'b0, 100, n);
        check_lat("reset_release_pll_reset", n);
    endtask

    task automatic test_clean_lock();
        int n;
        do_reset();
        exp_q.push_back(RC);
        wait_sig(0, 1'b0, 100, n);
        check_lat("clean_pll_reset_width", n);
        tick(10);
        bus.pll_lock = 1'b1;
        exp_q.push_back(LS + 3);
        wait_sig(1, 1'b1, 200, n);
        check_lat("clean_lock_latency", n);
        checks++;
        if (bus.rst_out_n !== 1'b1 || bus.retry_cnt !== 4'd0 || bus.pll_reset !== 1'b0) begin
            failures++;
            $display("FAIL clean_run_outputs: rst_out_n=%b retry=%0d pll_reset=%b required 1/0/0",
                     bus.rst_out_n, bus.retry_cnt, bus.pll_reset);
        end
    endtask

    task automatic test_lock_loss();
        int n;
        bus.pll_lock = 1'b0;
        exp_q.push_back(3);
        wait_sig(1, 1'b0, 50, n);
        check_lat("loss_latency", n);
        checks++;
        if (bus.rst_out_n !== 1'b0 || bus.pll_reset !== 1'b1 || bus.retry_cnt !== 4'd0) begin
            failures++;
            $display("FAIL loss_outputs: rst_out_n=%b pll_reset=%b retry=%0d required 0/1/0",
                     bus.rst_out_n, bus.pll_reset, bus.retry_cnt);
        end
        exp_q.push_back(RC);
        wait_sig(0, 1'b0, 100, n);
        check_lat("loss_repulse_width", n);
        bus.pll_lock = 1'b1;
        exp_q.push_back(LS + 3);
        wait_sig(1, 1'b1, 200, n);
        check_lat("loss_relock_latency", n);
    endtask

    task automatic test_glitch();
        int n;
        logic seen;
        do_reset();
        wait_sig(0, 1'b0, 100, n);
        bus.pll_lock = 1'b1;
        tick(8);
        bus.pll_lock = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            seen |= bus.locked;
        end
        bus.pll_lock = 1'b1;
        exp_q.push_back(LS + 3);
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (bus.locked === 1'b1) begin
                n = i;
                break;
            end
            n = -1;
        end
        check_lat("glitch_relock_latency", n);
        checks++;
        if (seen !== 1'b0 || bus.retry_cnt !== 4'd0) begin
            failures++;
            $display("FAIL glitch_outputs: locked_during_glitch=%b retry=%0d required 0/0", seen, bus.retry_cnt);
        end
    endtask

    task automatic test_single_timeout();
        int n;
        do_reset();
        wait_sig(0, 1'b0, 100, n);
        exp_q.push_back(LT);
        wait_sig(0, 1'b1, 200, n);
        check_lat("timeout_period", n);
        checks++;
        if (bus.retry_cnt !== 4'd1) begin
            failures++;
            $display("FAIL timeout_retry_cnt: got=%0d required=1", bus.retry_cnt);
        end
        exp_q.push_back(RC);
        wait_sig(0, 1'b0, 100, n);
        check_lat("timeout_repulse_width", n);
        bus.pll_lock = 1'b1;
        exp_q.push_back(LS + 3);
        wait_sig(1, 1'b1, 200, n);
        check_lat("timeout_then_lock", n);
        checks++;
        if (bus.retry_cnt !== 4'd1) begin
            failures++;
            $display("FAIL timeout_run_retry_cnt: got=%0d required=1", bus.retry_cnt);
        end
    endtask

    task automatic test_fault();
        int n;
        do_reset();
        exp_q.push_back(MR * (RC + LT));
        wait_sig(2, 1'b1, 1000, n);
        check_lat("fault_latency", n);
        checks++;
        if (bus.pll_reset !== 1'b1 || bus.retry_cnt !== 4'(MR) || bus.rst_out_n !== 1'b0 || bus.locked !== 1'b0) begin
            failures++;
            $display("FAIL fault_outputs: pll_reset=%b retry=%0d rst_out_n=%b locked=%b required 1/%0d/0/0",
                     bus.pll_reset, bus.retry_cnt, bus.rst_out_n, bus.locked, MR);
        end
        bus.pll_lock = 1'b1;
        tick(100);
        checks++;
        if (bus.fault !== 1'b1 || bus.pll_reset !== 1'b1 || bus.retry_cnt !== 4'(MR) || bus.rst_out_n !== 1'b0) begin
            failures++;
            $display("FAIL fault_sticky: fault=%b pll_reset=%b retry=%0d rst_out_n=%b required 1/1/%0d/0",
                     bus.fault, bus.pll_reset, bus.retry_cnt, bus.rst_out_n, MR);
        end
        #3 sys_rst_n = 1'b0;
        #1;
        checks++;
        if (bus.fault !== 1'b0 || bus.retry_cnt !== 4'd0 || bus.pll_reset !== 1'b1 || bus.rst_out_n !== 1'b0) begin
            failures++;
            $display("FAIL fault_async_clear: fault=%b retry=%0d pll_reset=%b rst_out_n=%b required 0/0/1/0",
                     bus.fault, bus.retry_cnt, bus.pll_reset, bus.rst_out_n);
        end
        bus.pll_lock = 1'b0;
    endtask

    task automatic test_tie(input int raise_at, input logic expect_retry);
        int n;
        do_reset();
        wait_sig(0, 1'b0, 100, n);
        tick(raise_at);
        bus.pll_lock = 1'b1;
        tick(2);
        checks++;
        if (bus.retry_cnt !== {3'd0, expect_retry} || bus.pll_reset !== expect_retry) begin
            failures++;
            $display("FAIL tie_%0d: retry=%0d pll_reset=%b required %0d/%b",
                     raise_at, bus.retry_cnt, bus.pll_reset, expect_retry, expect_retry);
        end
        if (!expect_retry) begin
            exp_q.push_back(LS + 3 - 2);
            wait_sig(1, 1'b1, 200, n);
            check_lat("tie_lock_latency", n);
        end
    endtask

    initial begin
        bus.pll_lock = 1'b0;
        test_reset();
        test_clean_lock();
        test_lock_loss();
        test_glitch();
        test_single_timeout();
        test_fault();
        test_tie(LT - 3, 1'b0);
        test_tie(LT - 2, 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
